// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: elastic chain of STAGES pipeline registers, WIDTH-bit payload.
// Stage 0 is the youngest and stage STAGES-1 is the oldest, driving the output.
// Features: valid/ready back-pressure, global stall, partial flush of the
// youngest FLUSH_STAGES stages, and a combinational occupancy count.
// Optional performance counters (stall_cnt_o, bubble_cnt_o) are built only
// when the macro PIPE_STAGE_CHAIN_PERF_EN is defined.
//
// Handshake: a word moves across the input when in_valid_i & in_ready_o,
// and across the output when out_valid_o & out_ready_i & !stall_i.
// in_ready_o never depends on in_valid_i, and out_valid_o never depends on
// out_ready_i.
module pipe_stage_chain #(
    parameter int WIDTH        = 32,
    parameter int STAGES       = 4,
    parameter int FLUSH_STAGES = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        in_valid_i,
    input  logic [WIDTH-1:0]            in_data_i,
    output logic                        in_ready_o,
    output logic                        out_valid_o,
    output logic [WIDTH-1:0]            out_data_o,
    input  logic                        out_ready_i,
    input  logic                        stall_i,
    input  logic                        flush_i,
    output logic [$clog2(STAGES+1)-1:0] occupancy_o
`ifdef PIPE_STAGE_CHAIN_PERF_EN
    ,
    output logic [31:0]                 stall_cnt_o,
    output logic [31:0]                 bubble_cnt_o
`endif
);

    localparam int OCC_W = $clog2(STAGES + 1);

    // Reject impossible configurations while elaborating.
    if (STAGES < 1 || FLUSH_STAGES < 0 || FLUSH_STAGES > STAGES) begin : g_bad_params
        $error("pipe_stage_chain: illegal STAGES/FLUSH_STAGES combination");
    end

    logic [STAGES-1:0] v;                 // per-stage valid bits
    logic [WIDTH-1:0]  d [STAGES];        // per-stage payload
    logic [STAGES-1:0] rdy;               // stage k may load this cycle
    logic [STAGES-1:0] up_v;              // valid offered to stage k
    logic [WIDTH-1:0]  up_d [STAGES];     // payload offered to stage k

    // Ready ripples from the consumer toward stage 0: a stage can load if it
    // is empty or everything downstream of it can move.
    always_comb begin
        logic acc;
        acc = out_ready_i;
        rdy = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc    = acc | ~v[k];
            rdy[k] = acc;
        end
    end

    assign in_ready_o = rdy[0] & ~stall_i & ~flush_i & ~rst_i;

    // What each stage would load: the producer for stage 0, otherwise the
    // next-younger stage, which looks empty if this cycle's flush kills it.
    always_comb begin
        up_v    = '0;
        up_v[0] = in_valid_i & in_ready_o;
        up_d[0] = in_data_i;
        for (int k = 1; k < STAGES; k++) begin
            up_v[k] = v[k-1] & ~(flush_i && ((k - 1) < FLUSH_STAGES));
            up_d[k] = d[k-1];
        end
    end

    // Stage registers: flush kills the young stages even under stall; other
    // stages load when ready and not stalled. Bubbles keep their old data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v <= '0;
            for (int k = 0; k < STAGES; k++) begin
                d[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (flush_i && (k < FLUSH_STAGES)) begin
                    v[k] <= 1'b0;
                end else if (!stall_i && rdy[k]) begin
                    v[k] <= up_v[k];
                    if (up_v[k]) begin
                        d[k] <= up_d[k];
                    end
                end
            end
        end
    end

    assign out_valid_o = v[STAGES-1] & ~rst_i;
    assign out_data_o  = rst_i ? '0 : d[STAGES-1];

    // Occupancy is the population count of the valid bits.
    always_comb begin
        occupancy_o = '0;
        if (!rst_i) begin
            for (int k = 0; k < STAGES; k++) begin
                occupancy_o = occupancy_o + OCC_W'(v[k]);
            end
        end
    end

`ifdef PIPE_STAGE_CHAIN_PERF_EN
    // Saturating counters of stalled cycles and of cycles where the consumer
    // was ready but the chain had nothing to offer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o  <= '0;
            bubble_cnt_o <= '0;
        end else begin
            if (stall_i && (stall_cnt_o != 32'hFFFF_FFFF)) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (!out_valid_o && out_ready_i && (bubble_cnt_o != 32'hFFFF_FFFF)) begin
                bubble_cnt_o <= bubble_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain (WIDTH=8, STAGES=4, FLUSH_STAGES=2): directed
// scenarios followed by random traffic, checked against a slot model and an
// in-order word scoreboard.
module tb_pipe_stage_chain;

    localparam int W  = 8;
    localparam int S  = 4;
    localparam int FS = 2;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic         stall;
    logic         flush;
    logic [2:0]   occupancy;
`ifdef PIPE_STAGE_CHAIN_PERF_EN
    logic [31:0]  stall_cnt;
    logic [31:0]  bubble_cnt;
`endif

    int n_vec;
    int n_err;

    // Slot model: m_v/m_d[k] describe stage k (0 youngest).
    logic         m_v [S];
    logic [W-1:0] m_d [S];
    logic [W-1:0] exp_q [$];
    logic [31:0]  m_stall_cnt;
    logic [31:0]  m_bubble_cnt;

    pipe_stage_chain #(
        .WIDTH(W),
        .STAGES(S),
        .FLUSH_STAGES(FS)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .in_valid_i(in_valid),
        .in_data_i(in_data),
        .in_ready_o(in_ready),
        .out_valid_o(out_valid),
        .out_data_o(out_data),
        .out_ready_i(out_ready),
        .stall_i(stall),
        .flush_i(flush),
        .occupancy_o(occupancy)
`ifdef PIPE_STAGE_CHAIN_PERF_EN
        ,
        .stall_cnt_o(stall_cnt),
        .bubble_cnt_o(bubble_cnt)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
    task automatic step(input logic iv, input logic [W-1:0] id, input logic ordy,
                        input logic st, input logic fl, input logic rs);
        logic         hole;
        logic         exp_rdy;
        logic         xfer;
        logic         acc;
        int           n_occ;
        int           e;
        int           killed;
        logic         nv [S];
        logic [W-1:0] nd [S];
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        stall     = st;
        flush     = fl;
        rst       = rs;
        @(negedge clk);
        hole  = 1'b0;
        n_occ = 0;
        for (int k = 0; k < S; k++) begin
            if (!m_v[k]) hole = 1'b1;
            else n_occ++;
        end
        exp_rdy = !rs && !st && !fl && (ordy || hole);
        xfer    = 1'b0;
        if (rs) begin
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_occ", 32'(occupancy), 32'd0);
            chk("rst_ready", 32'(in_ready), 32'd0);
            chk("rst_data", 32'(out_data), 32'd0);
            for (int k = 0; k < S; k++) begin
                m_v[k] = 1'b0;
                m_d[k] = '0;
            end
            exp_q.delete();
            m_stall_cnt  = '0;
            m_bubble_cnt = '0;
        end else begin
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("out_valid", 32'(out_valid), 32'(m_v[S-1]));
            chk("occupancy", 32'(occupancy), 32'(n_occ));
            if (m_v[S-1]) chk("out_data", 32'(out_data), 32'(m_d[S-1]));
            xfer = ordy && m_v[S-1] && !st;
            if (xfer)
                chk("sb_order", 32'(out_data), exp_q.size() > 0 ? 32'(exp_q[0]) : 32'hFFFF_FFFF);
`ifdef PIPE_STAGE_CHAIN_PERF_EN
            chk("stall_cnt", stall_cnt, m_stall_cnt);
            chk("bubble_cnt", bubble_cnt, m_bubble_cnt);
`endif
            // Next state: if the output moves or a hole exists, everything at or
            // below the highest hole (or the whole chain) shifts one place older.
            acc = iv && exp_rdy;
            for (int k = 0; k < S; k++) begin
                nv[k] = m_v[k];
                nd[k] = m_d[k];
            end
            if (!st && (ordy || hole)) begin
                e = S - 1;
                if (!ordy) begin
                    for (int k = 0; k < S; k++) if (!m_v[k]) e = k;
                end
                for (int k = e; k >= 1; k--) begin
                    nv[k] = m_v[k-1] && !(fl && ((k - 1) < FS));
                    if (m_v[k-1]) nd[k] = m_d[k-1];
                end
                nv[0] = acc;
                if (acc) nd[0] = id;
            end
            killed = 0;
            if (fl) begin
                for (int k = 0; k < FS; k++) begin
                    nv[k] = 1'b0;
                    if (m_v[k] && !(xfer && k == S - 1)) killed++;
                end
            end
            if (xfer && exp_q.size() > 0) void'(exp_q.pop_front());
            repeat (killed) if (exp_q.size() > 0) void'(exp_q.pop_back());
            if (acc) exp_q.push_back(id);
            if (st && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
            if (!m_v[S-1] && ordy && m_bubble_cnt != 32'hFFFF_FFFF) m_bubble_cnt++;
            for (int k = 0; k < S; k++) begin
                m_v[k] = nv[k];
                m_d[k] = nd[k];
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_stall_cnt  = '0;
        m_bubble_cnt = '0;
        for (int k = 0; k < S; k++) begin
            m_v[k] = 1'b0;
            m_d[k] = '0;
        end
        in_valid = 0; in_data = '0; out_ready = 0; stall = 0; flush = 0; rst = 1;
        @(posedge clk);
        #1;
        step(0, 8'h00, 0, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0, 1);

        // Single word latency.
        step(1, 8'hA5, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 0, 0);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_data", 32'(out_data), 32'hA5);
        for (int i = 0; i < 2; i++) step(0, 8'h00, 1, 0, 0, 0);

        // Back-to-back stream.
        for (int i = 1; i <= 16; i++) step(1, W'(i), 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0, 0, 0);

        // Back-pressure: 6 offered, 4 fit.
        for (int i = 0; i < 6; i++) step(1, W'(8'h21 + i), 0, 0, 0, 0);
        chk("bp_occ", 32'(occupancy), 32'd4);
        chk("bp_head", 32'(out_data), 32'h21);
        for (int i = 0; i < 6; i++) step(0, 8'h00, 1, 0, 0, 0);

        // Full chain then stall for three cycles.
        for (int i = 1; i <= 4; i++) step(1, W'(8'h11 * i), 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 8'h99, 1, 1, 0, 0);
        chk("stall_occ", 32'(occupancy), 32'd4);
        chk("stall_head", 32'(out_data), 32'h11);
        for (int i = 0; i < 6; i++) step(0, 8'h00, 1, 0, 0, 0);

        // Flush of a full, back-pressured chain.
        for (int i = 5; i <= 8; i++) step(1, W'(8'h11 * i), 0, 0, 0, 0);
        step(1, 8'hEE, 0, 0, 1, 0);
        chk("flush_occ", 32'(occupancy), 32'd2);
        chk("flush_head", 32'(out_data), 32'h55);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0, 0, 0);

        // Reset while full and stalled.
        for (int i = 0; i < 4; i++) step(1, W'(8'hA1 + i), 0, 0, 0, 0);
        step(0, 8'h00, 1, 1, 0, 0);
        step(0, 8'h00, 1, 1, 0, 1);
        chk("rst_full_valid", 32'(out_valid), 32'd0);
        chk("rst_full_occ", 32'(occupancy), 32'd0);
`ifdef PIPE_STAGE_CHAIN_PERF_EN
        chk("perf_rst", stall_cnt, 32'd0);
`endif
        for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 1, 0, 0);
`ifdef PIPE_STAGE_CHAIN_PERF_EN
        chk("perf_stall3", stall_cnt, 32'd3);
`endif
        step(0, 8'h00, 1, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(99, 0) < 70,
                 W'($urandom_range(255, 0)),
                 $urandom_range(99, 0) < 65,
                 $urandom_range(99, 0) < 10,
                 $urandom_range(99, 0) < 6,
                 $urandom_range(199, 0) < 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
